// File: rtl/cfu_simd_mac.sv
// SIMD multiply-accumulate CFU: offset-corrected lane-wise MAC into a persistent accumulator,
// plus a plain 32-bit multiply, behind a single-command-in-flight valid/ready CFU bus.
module cfu_simd_mac #(
    parameter int unsigned LANES      = 4,
    parameter int unsigned LANE_W     = 8,
    parameter int unsigned OFF_W      = 9,
    parameter int unsigned ACC_W      = 32,
    parameter int unsigned MUL_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0
);

    localparam int unsigned PROD_W = LANE_W + OFF_W + 1;
    localparam int unsigned CNT_W  = $clog2(MUL_STAGES + 1) + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [CNT_W-1:0]          r_cnt;
    logic [31:0]               r_a;
    logic [31:0]               r_b;
    logic [9:0]                r_fid;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [OFF_W-1:0]   r_off;
    logic [31:0]               r_result;
    logic                      r_rsp_valid;
    logic [31:0]               r_mul_pipe [MUL_STAGES];
    logic signed [ACC_W-1:0]   r_sum_pipe [MUL_STAGES];

    logic                      w_accept;
    logic                      w_commit;
    logic                      w_rsp_done;
    logic [31:0]               w_mul;
    logic signed [ACC_W-1:0]   w_sum;
    logic signed [ACC_W-1:0]   w_mac_acc;
    logic signed [ACC_W-1:0]   w_acc_nxt;
    logic signed [OFF_W-1:0]   w_off_nxt;
    logic [31:0]               w_result;

    // Sum over lanes of (sext(a_i) + off) * sext(b_i), reduced modulo 2^ACC_W
    function automatic logic signed [ACC_W-1:0] mac_sum(
        input logic [31:0]             a,
        input logic [31:0]             b,
        input logic signed [OFF_W-1:0] off
    );
        logic signed [LANE_W-1:0] a_l;
        logic signed [LANE_W-1:0] b_l;
        logic signed [OFF_W:0]    a_o;
        logic signed [PROD_W-1:0] p;
        logic signed [ACC_W-1:0]  s;
        s = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            a_l = a[i*LANE_W +: LANE_W];
            b_l = b[i*LANE_W +: LANE_W];
            a_o = (OFF_W+1)'(a_l) + (OFF_W+1)'(off);
            p   = PROD_W'(a_o) * PROD_W'(b_l);
            s   = s + ACC_W'(p);
        end
        return s;
    endfunction

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (cmd_valid)                          w_state_nxt = ST_BUSY;
            ST_BUSY: if (r_cnt == CNT_W'(MUL_STAGES))        w_state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready)                          w_state_nxt = ST_IDLE;
            default:                                         w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        cmd_ready  = 1'b0;
        w_accept   = 1'b0;
        w_commit   = 1'b0;
        w_rsp_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                w_accept  = cmd_valid;
            end
            ST_BUSY: w_commit   = (r_cnt == CNT_W'(MUL_STAGES));
            ST_RESP: w_rsp_done = rsp_ready;
            default: ;
        endcase
    end

    // Command capture and latency counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_fid <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_a   <= cmd_payload_inputs_0;
            r_b   <= cmd_payload_inputs_1;
            r_fid <= cmd_payload_function_id;
            r_cnt <= '0;
        end else if (r_state == ST_BUSY) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_mul = r_a * r_b;
    assign w_sum = mac_sum(r_a, r_b, r_off);

    // Multiplier pipeline; operands stay in the capture registers while busy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < int'(MUL_STAGES); k++) begin
                r_mul_pipe[k] <= '0;
                r_sum_pipe[k] <= '0;
            end
        end else if (r_state == ST_BUSY) begin
            r_mul_pipe[0] <= w_mul;
            r_sum_pipe[0] <= w_sum;
            for (int k = 1; k < int'(MUL_STAGES); k++) begin
                r_mul_pipe[k] <= r_mul_pipe[k-1];
                r_sum_pipe[k] <= r_sum_pipe[k-1];
            end
        end
    end

    assign w_mac_acc = r_acc + r_sum_pipe[MUL_STAGES-1];

    // Op decode; any nonzero modifier makes the op a no-op returning zero
    always_comb begin
        w_acc_nxt = r_acc;
        w_off_nxt = r_off;
        w_result  = '0;
        if (r_fid[9:3] == 7'd0) begin
            case (r_fid[2:0])
                3'd0: w_result = r_mul_pipe[MUL_STAGES-1];
                3'd1: begin
                    w_off_nxt = r_a[OFF_W-1:0];
                    w_acc_nxt = '0;
                end
                3'd2: begin
                    w_acc_nxt = w_mac_acc;
                    w_result  = 32'(w_mac_acc);
                end
                3'd3: w_result = 32'(r_acc);
                3'd4: begin
                    w_result  = 32'(r_acc);
                    w_acc_nxt = '0;
                end
                default: ;
            endcase
        end
    end

    // Architectural state and response registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc       <= '0;
            r_off       <= '0;
            r_result    <= '0;
            r_rsp_valid <= 1'b0;
        end else if (w_commit) begin
            r_acc       <= w_acc_nxt;
            r_off       <= w_off_nxt;
            r_result    <= w_result;
            r_rsp_valid <= 1'b1;
        end else if (w_rsp_done) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid             = r_rsp_valid;
    assign rsp_payload_outputs_0 = r_result;

endmodule

// File: tb/tb_cfu_simd_mac.sv
// Directed bench for cfu_simd_mac: default instance plus a 16-bit-accumulator instance for wrap.
module tb_cfu_simd_mac;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid [2];
    logic [9:0]  fid       [2];
    logic [31:0] op_a      [2];
    logic [31:0] op_b      [2];
    logic        rsp_ready [2];

    logic        cr0, rv0, cr1, rv1;
    logic [31:0] rd0, rd1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cfu_simd_mac u_dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .cmd_valid               (cmd_valid[0]),
        .cmd_ready               (cr0),
        .cmd_payload_function_id (fid[0]),
        .cmd_payload_inputs_0    (op_a[0]),
        .cmd_payload_inputs_1    (op_b[0]),
        .rsp_valid               (rv0),
        .rsp_ready               (rsp_ready[0]),
        .rsp_payload_outputs_0   (rd0)
    );

    cfu_simd_mac #(.ACC_W(16)) u_dut16 (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .cmd_valid               (cmd_valid[1]),
        .cmd_ready               (cr1),
        .cmd_payload_function_id (fid[1]),
        .cmd_payload_inputs_0    (op_a[1]),
        .cmd_payload_inputs_1    (op_b[1]),
        .rsp_valid               (rv1),
        .rsp_ready               (rsp_ready[1]),
        .rsp_payload_outputs_0   (rd1)
    );

    function automatic logic rv(input int d);
        return (d == 0) ? rv0 : rv1;
    endfunction

    function automatic logic cr(input int d);
        return (d == 0) ? cr0 : cr1;
    endfunction

    function automatic logic [31:0] rd(input int d);
        return (d == 0) ? rd0 : rd1;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one command; optionally hold rsp_ready low for `hold` cycles once the response is up
    task automatic do_op(input int d, input logic [9:0] f, input logic [31:0] av,
                         input logic [31:0] bv, input int hold,
                         output logic [31:0] res, output int lat);
        @(negedge clk);
        rsp_ready[d] = (hold == 0);
        cmd_valid[d] = 1'b1;
        fid[d]       = f;
        op_a[d]      = av;
        op_b[d]      = bv;
        @(posedge clk);
        #1;
        cmd_valid[d] = 1'b0;
        fid[d]       = 10'($urandom);
        op_a[d]      = $urandom;
        op_b[d]      = $urandom;
        lat = 0;
        while (!rv(d) && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = rd(d);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            check_eq("hold_data", rd(d), res);
            check_eq("hold_valid", 32'(rv(d)), 32'd1);
            check_eq("hold_cmd_ready", 32'(cr(d)), 32'd0);
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rsp_drop", 32'(rv(d)), 32'd0);
    endtask

    task automatic op_chk(input string tag, input int d, input logic [9:0] f,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp, input int hold);
        logic [31:0] r;
        int          lat;
        do_op(d, f, av, bv, hold, r, lat);
        check_eq(tag, r, exp);
        check_eq({tag, "_lat"}, 32'(lat), 32'd3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            cmd_valid[d] = 1'b0;
            fid[d]       = '0;
            op_a[d]      = '0;
            op_b[d]      = '0;
            rsp_ready[d] = 1'b1;
        end
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_rsp_valid", 32'(rv0), 32'd0);
        check_eq("rst_cmd_ready", 32'(cr0), 32'd1);
        check_eq("rst_payload", rd0, 32'd0);
        check_eq("rst_rsp_valid16", 32'(rv1), 32'd0);

        // Build up acc=10, then reset in the middle of another MAC
        op_chk("setoff0_a", 0, 10'd1, 32'h0, 32'h0, 32'h0, 0);
        op_chk("mac_pre", 0, 10'd2, 32'h01020304, 32'h01010101, 32'd10, 0);
        @(negedge clk);
        cmd_valid[0] = 1'b1;
        fid[0]       = 10'd2;
        op_a[0]      = 32'h01020304;
        op_b[0]      = 32'h01010101;
        @(posedge clk);
        #1;
        cmd_valid[0] = 1'b0;
        check_eq("busy_cmd_ready", 32'(cr0), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("midrst_rsp_valid", 32'(rv0), 32'd0);
        check_eq("midrst_payload", rd0, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_rst_cmd_ready", 32'(cr0), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("post_rst_rsp_valid", 32'(rv0), 32'd0);
        op_chk("rdacc_after_rst", 0, 10'd3, 32'h0, 32'h0, 32'h0, 0);

        // MUL32
        op_chk("mul_a", 0, 10'd0, 32'h00010003, 32'h00000005, 32'h0005000F, 0);
        op_chk("mul_b", 0, 10'd0, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 0);

        // MAC with zero offset, clear and read
        op_chk("setoff0_b", 0, 10'd1, 32'h0, 32'h0, 32'h0, 0);
        op_chk("mac_10", 0, 10'd2, 32'h01020304, 32'h01010101, 32'd10, 0);
        op_chk("mac_20", 0, 10'd2, 32'h01020304, 32'h01010101, 32'd20, 0);
        op_chk("clracc", 0, 10'd4, 32'h0, 32'h0, 32'd20, 0);
        op_chk("rdacc_0", 0, 10'd3, 32'h0, 32'h0, 32'd0, 0);

        // Offset 128 lane extremes
        op_chk("setoff128", 0, 10'd1, 32'd128, 32'h0, 32'h0, 0);
        op_chk("mac_zero", 0, 10'd2, 32'h80808080, 32'h7F7F7F7F, 32'h0, 0);
        op_chk("mac_neg4", 0, 10'd2, 32'h81818181, 32'hFFFFFFFF, 32'hFFFFFFFC, 0);

        // 16-bit accumulator wrap and sign extension
        op_chk("w16_setoff", 1, 10'd1, 32'h0, 32'h0, 32'h0, 0);
        op_chk("w16_mac1", 1, 10'd2, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'hFFFFFC04, 0);
        op_chk("w16_mac2", 1, 10'd2, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'hFFFFF808, 0);
        op_chk("w16_rdacc", 1, 10'd3, 32'h0, 32'h0, 32'hFFFFF808, 0);

        // Backpressure, then illegal / reserved ops leave acc alone
        op_chk("bp_rdacc", 0, 10'd3, 32'h0, 32'h0, 32'hFFFFFFFC, 10);
        op_chk("illegal_mod", 0, 10'h00A, 32'h01010101, 32'h01010101, 32'h0, 0);
        op_chk("rsvd_op5", 0, 10'd5, 32'h01010101, 32'h01010101, 32'h0, 0);
        op_chk("illegal_setoff", 0, 10'h009, 32'h00000005, 32'h0, 32'h0, 0);
        op_chk("rdacc_kept", 0, 10'd3, 32'h0, 32'h0, 32'hFFFFFFFC, 0);
        op_chk("mac_off_kept", 0, 10'd2, 32'h81818181, 32'hFFFFFFFF, 32'hFFFFFFF8, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
